// File: rtl/spi_runner_pkg.sv
// Shared definitions for the SPI running-light master.
//   state_e     : transfer FSM states
//   SYNC_STAGES : depth of the input synchronisers
//   rotl/rotr   : rotate the low w bits of a vector by one position
package spi_runner_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MAX_W       = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StHold
    } state_e;

    // Bits at and above w must be zero on entry.
    // For w == MAX_W the shift wraps to zero and the mask becomes all ones.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        return ((v >> 1) | (v << (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing for one SPI transfer.
//   clk_i, rst_ni  : system clock, asynchronous active-low reset
//   run_i          : transfer in progress; enables the divider
//   shift_i        : FSM is in the shift phase; enables SCLK toggling
//   tick_o         : divider reaches the end of a half-period this cycle
//   sclk_o         : SPI clock, CPOL while not shifting
//   lead_edge_o    : a leading SCLK edge happens at the next clock edge
//   trail_edge_o   : a trailing SCLK edge happens at the next clock edge
//   last_edge_o    : the pending edge is the final one of the word
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CPOL    = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic shift_i,
    output logic tick_o,
    output logic sclk_o,
    output logic lead_edge_o,
    output logic trail_edge_o,
    output logic last_edge_o
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGES  = 2 * DATA_W;
    localparam int unsigned EDGE_W = $clog2(EDGES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);
    localparam logic              IDLE_LVL  = 1'(CPOL);

    logic [DIV_W-1:0]  div_cnt_q;
    logic [EDGE_W-1:0] edge_cnt_q;
    logic              sclk_q;
    logic              edge_now;

    assign tick_o   = run_i && (div_cnt_q == DIV_LAST);
    assign edge_now = shift_i && tick_o;

    // Even edge count -> leading edge, odd -> trailing edge.
    assign lead_edge_o  = edge_now && !edge_cnt_q[0];
    assign trail_edge_o = edge_now && edge_cnt_q[0];
    assign last_edge_o  = (edge_cnt_q == EDGE_LAST);
    assign sclk_o       = sclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else if (!run_i || tick_o) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
            sclk_q     <= IDLE_LVL;
        end else if (!shift_i) begin
            edge_cnt_q <= '0;
            sclk_q     <= IDLE_LVL;
        end else if (tick_o) begin
            edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
            sclk_q     <= ~sclk_q;
        end
    end

endmodule

// File: rtl/spi_runner_master.sv
// SPI master driving a running-light pattern to a slave LED board.
//   sys_clk, rstn : system clock, asynchronous active-low reset
//   t_start, up   : active-low asynchronous buttons (send / toggle direction)
//   miso          : serial data from slave
//   cs, sclk, mosi: SPI outputs (cs active low)
//   led           : current pattern
//   rx_data       : last word received
//   busy          : high while cs is low
//   done          : one-cycle pulse when a transfer completes
module spi_runner_master
    import spi_runner_pkg::*;
#(
    parameter int unsigned LED_W       = 6,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              t_start,
    input  logic              up,
    input  logic              miso,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    output logic [LED_W-1:0]  led,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    if (LED_W < 1 || LED_W > DATA_W || LED_W > MAX_W || DATA_W < 2 || CLK_DIV < 1)
    begin : g_bad_params
        $error("spi_runner_master: illegal parameter combination");
    end

    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST =
        AUTO_W'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);

    // Input conditioning
    logic [SYNC_STAGES-1:0] start_sync_q, up_sync_q, miso_sync_q;
    logic start_prev_q, up_prev_q, start_ev_q, up_ev_q;
    logic start_s, up_s, miso_s;

    assign start_s = start_sync_q[SYNC_STAGES-1];
    assign up_s    = up_sync_q[SYNC_STAGES-1];
    assign miso_s  = miso_sync_q[SYNC_STAGES-1];

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            start_sync_q <= '1;
            up_sync_q    <= '1;
            miso_sync_q  <= '0;
            start_prev_q <= 1'b1;
            up_prev_q    <= 1'b1;
            start_ev_q   <= 1'b0;
            up_ev_q      <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], t_start};
            up_sync_q    <= {up_sync_q[SYNC_STAGES-2:0], up};
            miso_sync_q  <= {miso_sync_q[SYNC_STAGES-2:0], miso};
            start_prev_q <= start_s;
            up_prev_q    <= up_s;
            // Registered falling-edge events
            start_ev_q   <= start_prev_q & ~start_s;
            up_ev_q      <= up_prev_q & ~up_s;
        end
    end

    // Auto-run timer
    logic [AUTO_W-1:0] auto_cnt_q;
    logic              auto_tick;

    assign auto_tick = (AUTO_PERIOD != 0) && (auto_cnt_q == AUTO_LAST);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            auto_cnt_q <= '0;
        end else if (AUTO_PERIOD == 0 || auto_tick) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
        end
    end

    // SCLK generator
    state_e state_q, state_d;
    logic   tick, lead_edge, trail_edge, last_edge;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W),
        .CPOL    (CPOL)
    ) u_sclk_gen (
        .clk_i        (sys_clk),
        .rst_ni       (rstn),
        .run_i        (state_q != StIdle),
        .shift_i      (state_q == StShift),
        .tick_o       (tick),
        .sclk_o       (sclk),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .last_edge_o  (last_edge)
    );

    logic req, start;
    logic pend_q, pend_d;

    assign req   = start_ev_q | auto_tick;
    assign start = (state_q == StIdle) && (req || pend_q);

    // FSM: state register
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req || pend_q)            state_d = StSetup;
            StSetup: if (tick)                     state_d = StShift;
            StShift: if (trail_edge && last_edge)  state_d = StHold;
            StHold:  if (tick)                     state_d = StIdle;
            default:                               state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cs   = 1'b1;
        busy = 1'b0;
        if (state_q != StIdle) begin
            cs   = 1'b0;
            busy = 1'b1;
        end
    end

    // Datapath
    logic [LED_W-1:0]  led_q, led_d, rot_l, rot_r;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] tx_q, tx_d, tx_shift;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic              mosi_q, mosi_d, done_q, done_d;
    logic              shift_edge, samp_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    assign rot_l    = LED_W'(rotl(MAX_W'(led_q), LED_W));
    assign rot_r    = LED_W'(rotr(MAX_W'(led_q), LED_W));
    assign tx_shift = (MSB_FIRST != 0) ? (tx_q << 1) : (tx_q >> 1);

    // CPHA=0 presents bit 0 before the first edge, so no shift follows the final trailing edge.
    assign shift_edge = (CPHA == 0) ? (trail_edge && !last_edge) : lead_edge;
    assign samp_edge  = (CPHA == 0) ? lead_edge : trail_edge;

    always_comb begin
        led_d     = led_q;
        dir_d     = dir_q ^ up_ev_q;  // a coincident up event affects this rotation
        pend_d    = pend_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        if (start) begin
            pend_d          = 1'b0;
            led_d           = dir_d ? rot_r : rot_l;
            tx_d            = '0;
            tx_d[LED_W-1:0] = led_d;
            rx_sh_d         = '0;
            mosi_d          = (CPHA == 0) ? first_bit(tx_d) : 1'b0;
        end else if (req && state_q != StIdle) begin
            pend_d = 1'b1;
        end

        if (state_q == StShift) begin
            if (shift_edge) begin
                tx_d   = tx_shift;
                mosi_d = (CPHA == 0) ? first_bit(tx_shift) : first_bit(tx_q);
            end
            if (samp_edge) begin
                rx_sh_d = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], miso_s}
                                           : {miso_s, rx_sh_q[DATA_W-1:1]};
            end
        end

        if (state_q == StHold && tick) begin
            rx_data_d = rx_sh_q;
            done_d    = 1'b1;
            mosi_d    = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            led_q     <= LED_W'(1);
            dir_q     <= 1'b0;
            pend_q    <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign led     = led_q;
    assign rx_data = rx_data_q;
    assign mosi    = mosi_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_runner_master.sv
// Bench for spi_runner_master: default instance in mosi->miso loopback, a mode-3
// LSB-first instance with miso tied high, and an auto-run instance.
module tb_spi_runner_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance (loopback)
    logic       rstn_def, t_start_def, up_def;
    logic       cs_def, sclk_def, mosi_def, busy_def, done_def;
    logic [5:0] led_def;
    logic [7:0] rx_def;

    spi_runner_master u_def (
        .sys_clk (clk),
        .rstn    (rstn_def),
        .t_start (t_start_def),
        .up      (up_def),
        .miso    (mosi_def),
        .cs      (cs_def),
        .sclk    (sclk_def),
        .mosi    (mosi_def),
        .led     (led_def),
        .rx_data (rx_def),
        .busy    (busy_def),
        .done    (done_def)
    );

    // Mode 3, LSB first, CLK_DIV=2, miso held high
    logic       rstn_m3, t_start_m3;
    logic       cs_m3, sclk_m3, mosi_m3, busy_m3, done_m3;
    logic [5:0] led_m3;
    logic [7:0] rx_m3;

    spi_runner_master #(
        .CLK_DIV   (2),
        .CPOL      (1),
        .CPHA      (1),
        .MSB_FIRST (0)
    ) u_m3 (
        .sys_clk (clk),
        .rstn    (rstn_m3),
        .t_start (t_start_m3),
        .up      (1'b1),
        .miso    (1'b1),
        .cs      (cs_m3),
        .sclk    (sclk_m3),
        .mosi    (mosi_m3),
        .led     (led_m3),
        .rx_data (rx_m3),
        .busy    (busy_m3),
        .done    (done_m3)
    );

    // Auto-run instance
    logic       rstn_auto;
    logic       cs_auto, sclk_auto, mosi_auto, busy_auto, done_auto;
    logic [5:0] led_auto;
    logic [7:0] rx_auto;

    spi_runner_master #(
        .AUTO_PERIOD (200)
    ) u_auto (
        .sys_clk (clk),
        .rstn    (rstn_auto),
        .t_start (1'b1),
        .up      (1'b1),
        .miso    (1'b0),
        .cs      (cs_auto),
        .sclk    (sclk_auto),
        .mosi    (mosi_auto),
        .led     (led_auto),
        .rx_data (rx_auto),
        .busy    (busy_auto),
        .done    (done_auto)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the default instance: expected words pushed when a press is driven,
    // popped and compared when done pulses.
    logic [7:0] exp_q[$];
    logic [7:0] cap_word, exp_word;
    logic       prev_cs_m = 1'b1, prev_sclk_m = 1'b0;
    int         cap_bits = 0, cap_len = 0, done_cnt_def = 0;

    always @(negedge clk) begin
        if (!rstn_def) begin
            prev_cs_m   = 1'b1;
            prev_sclk_m = 1'b0;
        end else begin
            if (prev_cs_m && !cs_def) begin
                cap_word = '0;
                cap_bits = 0;
                cap_len  = 0;
            end
            if (!cs_def) cap_len++;
            if (!cs_def && !prev_sclk_m && sclk_def) begin
                cap_word = {cap_word[6:0], mosi_def};
                cap_bits++;
            end
            if (done_def) begin
                done_cnt_def++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected done: actual=done required=no transfer");
                end else begin
                    exp_word = exp_q.pop_front();
                    check("mosi word", 32'(cap_word), 32'(exp_word));
                    check("rx_data loopback", 32'(rx_def), 32'(exp_word));
                    check("sclk leading edges", 32'(cap_bits), 32'd8);
                    check("cs low length", 32'(cap_len), 32'd72);
                end
            end
            prev_cs_m   = cs_def;
            prev_sclk_m = sclk_def;
        end
    end

    task automatic wait_done_def(input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (done_def === 1'b1) seen = 1'b1;
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
    endtask

    // Press t_start for 2 cycles, measuring clock edges until cs falls.
    task automatic press_start_def(output int lat, output logic bsy);
        lat = 0;
        bsy = 1'b0;
        t_start_def = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 2) t_start_def = 1'b1;
            if (lat == 0 && cs_def == 1'b0) begin
                lat = n;
                bsy = busy_def;
            end
        end
    endtask

    task automatic pulse_start_def();
        t_start_def = 1'b0;
        repeat (2) @(negedge clk);
        t_start_def = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_up_def();
        up_def = 1'b0;
        repeat (2) @(negedge clk);
        up_def = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_m3(input logic [7:0] exp_w, input logic [5:0] exp_led);
        logic [7:0] w;
        logic       prev_s, seen, first;
        int         idx, len, idle_bad;
        w = '0; prev_s = 1'b1; seen = 1'b0; first = 1'b0;
        idx = 0; len = 0; idle_bad = 0;
        t_start_m3 = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) t_start_m3 = 1'b1;
            if (cs_m3) begin
                if (sclk_m3 !== 1'b1) idle_bad++;
            end else begin
                len++;
                // Trailing edge (rising for CPOL=1) is where the slave samples.
                if (!prev_s && sclk_m3) begin
                    if (idx == 0) first = mosi_m3;
                    if (idx < 8) w[idx] = mosi_m3;
                    idx++;
                end
            end
            prev_s = sclk_m3;
            if (done_m3) seen = 1'b1;
        end
        check("m3 done seen", 32'(seen), 32'd1);
        check("m3 mosi word lsb-first", 32'(w), 32'(exp_w));
        check("m3 first bit is pattern lsb", 32'(first), 32'(exp_w[0]));
        check("m3 sample edges", 32'(idx), 32'd8);
        check("m3 cs low length", 32'(len), 32'd36);
        check("m3 rx_data", 32'(rx_m3), 32'hFF);
        check("m3 led", 32'(led_m3), 32'(exp_led));
        check("m3 sclk idle high", 32'(idle_bad), 32'd0);
    endtask

    typedef struct {
        bit         up;
        logic [5:0] led;
        logic [7:0] word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, lowcnt, done_before;
        logic       bsy;
        int         falls[$];
        logic       prev_c;

        vecs[0] = '{up: 1'b0, led: 6'b000010, word: 8'h02};
        vecs[1] = '{up: 1'b1, led: 6'b000001, word: 8'h01};
        vecs[2] = '{up: 1'b0, led: 6'b100000, word: 8'h20};
        vecs[3] = '{up: 1'b1, led: 6'b000001, word: 8'h01};
        vecs[4] = '{up: 1'b0, led: 6'b000010, word: 8'h02};
        vecs[5] = '{up: 1'b1, led: 6'b000001, word: 8'h01};

        rstn_def = 1'b0; rstn_m3 = 1'b0; rstn_auto = 1'b0;
        t_start_def = 1'b1; up_def = 1'b1; t_start_m3 = 1'b1;
        repeat (3) @(negedge clk);

        check("reset cs", 32'(cs_def), 32'd1);
        check("reset sclk", 32'(sclk_def), 32'd0);
        check("reset mosi", 32'(mosi_def), 32'd0);
        check("reset led", 32'(led_def), 32'd1);
        check("reset rx_data", 32'(rx_def), 32'd0);
        check("reset busy", 32'(busy_def), 32'd0);
        check("reset done", 32'(done_def), 32'd0);
        check("reset m3 sclk", 32'(sclk_m3), 32'd1);
        check("reset m3 cs", 32'(cs_m3), 32'd1);

        rstn_def = 1'b1;
        rstn_m3  = 1'b1;
        repeat (3) @(negedge clk);

        // Table: rotation, direction and wrap in both directions
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].up) press_up_def();
            exp_q.push_back(vecs[i].word);
            press_start_def(lat, bsy);
            check($sformatf("start latency v%0d", i), 32'(lat), 32'd4);
            check($sformatf("busy at cs fall v%0d", i), 32'(bsy), 32'd1);
            wait_done_def($sformatf("v%0d", i));
            check($sformatf("led v%0d", i), 32'(led_def), 32'(vecs[i].led));
            repeat (5) @(negedge clk);
        end

        // Queueing: dir=1, led=000001; three presses during one transfer
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h10);
        press_start_def(lat, bsy);
        repeat (3) pulse_start_def();
        wait_done_def("queue first");
        @(negedge clk);
        check("back-to-back cs low", 32'(cs_def), 32'd0);
        wait_done_def("queue second");
        check("led after queue", 32'(led_def), 32'(6'b010000));
        lowcnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (!cs_def) lowcnt++;
        end
        check("no third transfer", 32'(lowcnt), 32'd0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-transfer
        done_before = done_cnt_def;
        press_start_def(lat, bsy);
        repeat (18) @(negedge clk);
        check("cs low before abort", 32'(cs_def), 32'd0);
        rstn_def = 1'b0;
        #1;
        check("abort cs", 32'(cs_def), 32'd1);
        check("abort sclk", 32'(sclk_def), 32'd0);
        check("abort led", 32'(led_def), 32'(6'b000001));
        check("abort busy", 32'(busy_def), 32'd0);
        check("abort rx_data", 32'(rx_def), 32'd0);
        repeat (3) @(negedge clk);
        rstn_def = 1'b1;
        repeat (120) @(negedge clk);
        check("no done after abort", 32'(done_cnt_def - done_before), 32'd0);
        check("cs idle after abort", 32'(cs_def), 32'd1);

        // Mode 3, LSB first
        run_m3(8'h02, 6'b000010);
        repeat (5) @(negedge clk);
        run_m3(8'h04, 6'b000100);

        // Auto-run
        rstn_auto = 1'b1;
        prev_c = 1'b1;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (prev_c && !cs_auto) falls.push_back(n);
            prev_c = cs_auto;
        end
        check("auto fall count", 32'(falls.size()), 32'd3);
        if (falls.size() >= 1) check("auto first fall", 32'(falls[0]), 32'd200);
        for (int i = 1; i < falls.size(); i++) begin
            check($sformatf("auto interval %0d", i), 32'(falls[i] - falls[i-1]), 32'd200);
        end
        check("auto led", 32'(led_auto), 32'(6'b001000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
